// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two WIDTH-bit operands by shifting them LSB first
// through a single one-bit full-adder cell, one bit per clock, with
// valid/ready handshakes on the operand side and on the result side.
// Optional feature macro: OVERFLOW_EN adds the signed-overflow output ovf.
module bit_serial_adder #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_EN
   output logic             co,
   output logic             ovf
`else
   output logic             co
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sreg;
   logic             carry;
   logic             fa_s;
   logic             fa_c;
`ifdef OVERFLOW_EN
   logic             cmsb;
`endif

   // The single full-adder cell, fed by the low bits of the operand shifters
   always_comb begin
      fa_s = sa[0] ^ sb[0] ^ carry;
      fa_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
   end

   // Handshake FSM and bit-serial datapath; outputs are all registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         sa        <= '0;
         sb        <= '0;
         sreg      <= '0;
         carry     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef OVERFLOW_EN
         cmsb      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sa       <= a;
                  sb       <= b;
                  carry    <= ci;
                  sreg     <= '0;
                  count    <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               sreg  <= {fa_s, sreg[WIDTH-1:1]};
               carry <= fa_c;
               count <= count + 1'b1;
               if (count == LAST_BIT) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef OVERFLOW_EN
                  cmsb      <= carry;
`endif
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign sum = sreg;
   assign co  = carry;

`ifdef OVERFLOW_EN
   // Signed overflow is the carry into the MSB disagreeing with the carry out
   assign ovf = out_valid & (cmsb ^ carry);
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: self-checking bench for bit_serial_adder (WIDTH=4).
// A cycle-level behavioural model (latency counter plus arithmetic results)
// is checked every cycle; directed cases pin literal results.
// Define OVERFLOW_EN to also exercise the ovf output.
module tb_bit_serial_adder;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;
   localparam int MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
`ifdef OVERFLOW_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit m_known = 1'b0;
   bit m_busy  = 1'b0;
   bit m_done  = 1'b0;
   bit m_fresh = 1'b0;
   int m_wait  = 0;
   int m_accepted  = 0;
   int m_delivered = 0;
   int exp_sum_q[$];
   int exp_co_q[$];
`ifdef OVERFLOW_EN
   int exp_ovf_q[$];
`endif

   bit_serial_adder #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
`ifdef OVERFLOW_EN
      .co       (co),
      .ovf      (ovf)
`else
      .co       (co)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkValue(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int signedOf(input int v);
      return (v >= MOD / 2) ? v - MOD : v;
   endfunction

   // Model: check outputs each negedge, then predict the next rising edge
   task automatic compareLoop();
      int s;
      forever begin
         @(negedge clk);
         if (m_known) begin
            checkValue("in_ready", int'(in_ready), int'(!m_busy));
            checkValue("out_valid", int'(out_valid), int'(m_done));
            if (m_done) begin
               checkValue("model_sum", int'(sum), exp_sum_q[0]);
               checkValue("model_co", int'(co), exp_co_q[0]);
`ifdef OVERFLOW_EN
               checkValue("model_ovf", int'(ovf), exp_ovf_q[0]);
`endif
            end
`ifdef OVERFLOW_EN
            else begin
               checkValue("ovf_quiet", int'(ovf), 0);
            end
`endif
            if (m_fresh) begin
               checkValue("reset_sum", int'(sum), 0);
               checkValue("reset_co", int'(co), 0);
            end
         end
         if (rst) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_fresh = 1'b1;
            exp_sum_q.delete();
            exp_co_q.delete();
`ifdef OVERFLOW_EN
            exp_ovf_q.delete();
`endif
         end else begin
            m_fresh = 1'b0;
            if (!m_busy) begin
               if (in_valid) begin
                  s = int'(a) + int'(b) + int'(ci);
                  exp_sum_q.push_back(s % MOD);
                  exp_co_q.push_back((s >= MOD) ? 1 : 0);
`ifdef OVERFLOW_EN
                  s = signedOf(int'(a)) + signedOf(int'(b)) + int'(ci);
                  exp_ovf_q.push_back((s > MOD / 2 - 1 || s < -MOD / 2) ? 1 : 0);
`endif
                  m_busy = 1'b1;
                  m_wait = WIDTH;
                  m_accepted++;
               end
            end else if (!m_done) begin
               m_wait--;
               if (m_wait == 0) m_done = 1'b1;
            end else if (out_ready) begin
               void'(exp_sum_q.pop_front());
               void'(exp_co_q.pop_front());
`ifdef OVERFLOW_EN
               void'(exp_ovf_q.pop_front());
`endif
               m_busy = 1'b0;
               m_done = 1'b0;
               m_delivered++;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tci);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkValue("wait_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      ci       = tci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      ci       = 1'($urandom);
   endtask

   task automatic waitResult(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkValue("wait_out_valid", int'(out_valid), 1);
   endtask

   task automatic checkOutput(input string name, input int exp_sum, input int exp_co);
      checkValue({name, "_sum"}, int'(sum), exp_sum);
      checkValue({name, "_co"}, int'(co), exp_co);
   endtask

   task automatic drainResult(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkValue({name, "_idle_ready"}, int'(in_ready), 1);
      checkValue({name, "_idle_valid"}, int'(out_valid), 0);
   endtask

   task automatic runStream(input int n, input bit exhaustive);
      int idx       = 0;
      int cyc       = 0;
      int start_del = m_delivered;
      int start_acc = m_accepted;
      bit acc;
      if (exhaustive) begin
         a  = WIDTH'(idx >> 5);
         b  = WIDTH'(idx >> 1);
         ci = 1'(idx);
      end else begin
         a  = WIDTH'($urandom);
         b  = WIDTH'($urandom);
         ci = 1'($urandom);
      end
      in_valid = 1'b1;
      while (idx < n && cyc < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            idx++;
            if (exhaustive) begin
               a  = WIDTH'(idx >> 5);
               b  = WIDTH'(idx >> 1);
               ci = 1'(idx);
            end else begin
               a  = WIDTH'($urandom);
               b  = WIDTH'($urandom);
               ci = 1'($urandom);
            end
         end
         if (!exhaustive) in_valid = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (m_delivered - start_del < n && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      checkValue("stream_accepted", m_accepted - start_acc, n);
      checkValue("stream_delivered", m_delivered - start_del, n);
   endtask

   // Directed cases, then exhaustive and random streams
   initial begin
      int lat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      fork
         compareLoop();
      join_none
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkValue("rst_in_ready", int'(in_ready), 1);
      checkValue("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst", 0, 0);

      applyStimulus(4'h5, 4'hA, 1'b0);
      waitResult(lat);
      checkValue("t1_latency", lat, WIDTH);
      checkOutput("t1", 15, 0);
      drainResult("t1");

      applyStimulus(4'hF, 4'h1, 1'b0);
      waitResult(lat);
      checkOutput("t2_wrap", 0, 1);
      drainResult("t2a");
      applyStimulus(4'hF, 4'hF, 1'b1);
      waitResult(lat);
      checkOutput("t2_full", 15, 1);
      drainResult("t2b");

      applyStimulus(4'h9, 4'h3, 1'b0);
      waitResult(lat);
      checkOutput("t3", 12, 0);
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'b0;
         in_valid  = (i == 2);
         a         = 4'h1;
         b         = 4'h2;
         @(posedge clk);
         #1;
         checkOutput("t3_hold", 12, 0);
         checkValue("t3_hold_in_ready", int'(in_ready), 0);
         checkValue("t3_hold_out_valid", int'(out_valid), 1);
      end
      in_valid = 1'b0;
      drainResult("t3");

      applyStimulus(4'h5, 4'h6, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkValue("t4_in_ready", int'(in_ready), 1);
      checkValue("t4_out_valid", int'(out_valid), 0);
      checkOutput("t4_abort", 0, 0);
      applyStimulus(4'h2, 4'h2, 1'b0);
      waitResult(lat);
      checkOutput("t4_fresh", 4, 0);
      drainResult("t4");

`ifdef OVERFLOW_EN
      applyStimulus(4'h7, 4'h1, 1'b0);
      waitResult(lat);
      checkOutput("t5a", 8, 0);
      checkValue("t5a_ovf", int'(ovf), 1);
      drainResult("t5a");
      applyStimulus(4'h8, 4'h8, 1'b0);
      waitResult(lat);
      checkOutput("t5b", 0, 1);
      checkValue("t5b_ovf", int'(ovf), 1);
      drainResult("t5b");
      applyStimulus(4'h3, 4'h4, 1'b0);
      waitResult(lat);
      checkOutput("t5c", 7, 0);
      checkValue("t5c_ovf", int'(ovf), 0);
      drainResult("t5c");
`endif

      runStream(512, 1'b1);
      runStream(80, 1'b0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
